// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: cascaded modulo-N up/down digit counter with load, wrap/saturate and terminal count
module bcd_updown_counter #(
  parameter int DIGITS = 2,
  parameter int MODULUS = 10,
  parameter int WRAP = 1
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  wrapped
);
  localparam logic [3:0] MAX = 4'(MODULUS - 1);
  // chain[i]: every digit below i sits at the rollover value for the current direction
  logic [DIGITS:0] chain;
  logic [4*DIGITS-1:0] nxt, clamped;
  logic term, hold;
  assign chain[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic [3:0] d, l;
    assign d = count[4*g +: 4];
    assign l = load_val[4*g +: 4];
    assign chain[g+1] = chain[g] & (up ? d == MAX : d == 4'd0);
    assign nxt[4*g +: 4] = !chain[g] ? d :
                           up ? (d == MAX ? 4'd0 : d + 4'd1) :
                                (d == 4'd0 ? MAX : d - 4'd1);
    assign clamped[4*g +: 4] = l > MAX ? MAX : l;
  end
  assign term = chain[DIGITS];
  assign hold = term && WRAP == 0;
  assign tc = en & ~load & term;
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      count   <= '0;
      wrapped <= 1'b0;
    end else if (load) begin
      count   <= clamped;
      wrapped <= 1'b0;
    end else if (en && !hold) begin
      count   <= nxt;
      wrapped <= term;
    end else begin
      wrapped <= 1'b0;
    end
  end
endmodule
